// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the memory subordinate.
// Transfer encodings, size codes, response codes and responder states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_ERR1,
        S_ERR2
    } slv_state_e;

endpackage

// File: rtl/ahb_lane_decoder.sv
// Address-phase byte-lane decode: HSIZE + HADDR[1:0] to strobe.
// Flags halfword/word accesses that are not naturally aligned.
module ahb_lane_decoder
    import ahb_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_i,
    output logic [3:0] strb_o,
    output logic       misalign_o
);

    always_comb begin
        strb_o     = 4'b0000;
        misalign_o = 1'b0;
        case (size_i)
            SIZE_BYTE: strb_o = 4'b0001 << addr_i;
            SIZE_HALF: begin
                strb_o     = 4'b0011 << addr_i;
                misalign_o = addr_i[0];
            end
            SIZE_WORD: begin
                strb_o     = 4'b1111;
                misalign_o = |addr_i;
            end
            default: strb_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite word-organised scratch memory with optional wait states.
// Out-of-range, misaligned or oversize accesses get a two-cycle ERROR.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          AW        = $clog2(MEM_DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);
    localparam logic [3:0]  WS_LOAD   =
        4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    slv_state_e    state_q;
    logic [3:0]    cnt_q;
    logic [AW-1:0] idx_q;
    logic [3:0]    strb_q;
    logic          write_q;
    logic          hreadyout_q;
    logic          hresp_q;
    logic [31:0]   mem_q [MEM_DEPTH];

    htrans_e    htrans;
    logic [3:0] strb;
    logic       misalign;
    logic       err;
    logic       samp;
    logic       unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    assign htrans = htrans_e'(HTRANS);
    assign samp   = HSEL && HREADY &&
                    (htrans == HT_NONSEQ || htrans == HT_SEQ);
    assign err    = (HSIZE > SIZE_WORD) || misalign ||
                    (HADDR >= MEM_BYTES);

    ahb_lane_decoder u_lane (
        .size_i     (HSIZE),
        .addr_i     (HADDR[1:0]),
        .strb_o     (strb),
        .misalign_o (misalign)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            strb_q      <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (state_q == S_XFER && write_q) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb_q[b]) begin
                        mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
                    end
                end
            end
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_XFER;
                        hreadyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                // IDLE, XFER and ERR2 all accept a new address phase
                default: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                    if (samp) begin
                        idx_q   <= HADDR[AW+1:2];
                        strb_q  <= strb;
                        write_q <= HWRITE;
                        if (err) begin
                            state_q     <= S_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state_q     <= S_WAIT;
                            cnt_q       <= WS_LOAD;
                            hreadyout_q <= 1'b0;
                        end else begin
                            state_q <= S_XFER;
                        end
                    end
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = (state_q == S_XFER && !write_q) ?
                       mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench: a zero-wait and a three-wait instance behind a mux.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_ahb_mem_slave;
    import ahb_pkg::*;

    typedef struct {
        logic        resp;
        logic        chk_data;
        logic [31:0] data;
        int          waits;
        string       name;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        sel = 1'b0;
    logic        hsel = 1'b0;
    logic [31:0] haddr = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [2:0]  hburst = '0;
    logic [1:0]  htrans = '0;
    logic [31:0] hwdata = '0;
    logic [31:0] rd0, rd3, hrdata;
    logic        ro0, ro3, hreadyout;
    logic        rs0, rs3, hresp;
    logic        hsel0, hsel3, hready;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pend = '0;

    always #5 HCLK = ~HCLK;

    assign hsel0     = hsel && !sel;
    assign hsel3     = hsel && sel;
    assign hreadyout = sel ? ro3 : ro0;
    assign hresp     = sel ? rs3 : rs0;
    assign hrdata    = sel ? rd3 : rd0;
    assign hready    = hreadyout;

    ahb_mem_slave #(.MEM_DEPTH(64), .WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(4'h3),
        .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(hready),
        .HWDATA(hwdata), .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
    );

    ahb_mem_slave #(.MEM_DEPTH(64), .WAIT_STATES(3)) u_ws3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(4'h3),
        .HTRANS(htrans), .HMASTLOCK(1'b0), .HREADY(hready),
        .HWDATA(hwdata), .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3)
    );

    function automatic void check(input string nm,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    logic active = 1'b0;
    logic idle_next = 1'b0;
    int   lowcnt = 0;

    always @(negedge HCLK) begin
        exp_t cur;
        if (!HRESETn) begin
            active    = 1'b0;
            idle_next = 1'b0;
            lowcnt    = 0;
            sb.delete();
        end else begin
            if (idle_next) begin
                check("idle_ready", 32'(hreadyout), 32'd1);
                check("idle_resp", 32'(hresp), 32'd0);
                idle_next = 1'b0;
            end
            if (active) begin
                if (!hreadyout) begin
                    lowcnt++;
                    if (sb.size() > 0)
                        check({sb[0].name, "_lowresp"}, 32'(hresp),
                              32'(sb[0].resp));
                end else begin
                    check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        cur = sb.pop_front();
                        check({cur.name, "_resp"}, 32'(hresp),
                              32'(cur.resp));
                        check({cur.name, "_waits"}, 32'(lowcnt),
                              32'(cur.waits));
                        if (cur.chk_data)
                            check({cur.name, "_data"}, hrdata, cur.data);
                    end
                    active = 1'b0;
                    lowcnt = 0;
                end
            end
            if (hsel && hready && htrans[1]) active = 1'b1;
            else if (hsel && hready) idle_next = 1'b1;
        end
    end

    task automatic beat(input logic [1:0] tr, input logic [31:0] a,
                        input logic wr, input logic [2:0] sz,
                        input logic [31:0] wd, input logic eresp,
                        input logic [31:0] edata, input string nm);
        exp_t e;
        int   n;
        logic rdy;
        hsel   = 1'b1;
        htrans = tr;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
        hwdata = pend;
        if (tr[1]) begin
            e.resp     = eresp;
            e.chk_data = !wr;
            e.data     = edata;
            e.waits    = eresp ? 1 : (sel ? 3 : 0);
            e.name     = nm;
            sb.push_back(e);
        end
        pend = (tr[1] && wr) ? wd : 32'h0;
        n = 0;
        do begin
            @(negedge HCLK);
            rdy = hready;
            @(posedge HCLK);
            #1;
            n++;
        end while (!rdy && n < 50);
        check({nm, "_accept"}, 32'(rdy), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            beat(HT_IDLE, 32'h0, 1'b0, SIZE_WORD, 32'h0, 1'b0, 32'h0,
                 "idle");
    endtask

    initial begin
        repeat (2) @(posedge HCLK);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_hreadyout", 32'(hreadyout), 32'd1);
            check("rst_hresp", 32'(hresp), 32'd0);
            check("rst_hrdata", hrdata, 32'h0);
        end
        sel = 1'b0;
        @(posedge HCLK);
        #2 HRESETn = 1'b1;

        beat(HT_NONSEQ, 32'h10, 1, SIZE_WORD, 32'hDEADBEEF, 0, 0, "w10");
        beat(HT_NONSEQ, 32'h10, 0, SIZE_WORD, 0, 0, 32'hDEADBEEF, "r10");
        idle(2);

        beat(HT_NONSEQ, 32'h21, 1, SIZE_BYTE, 32'h0000AA00, 0, 0, "wb21");
        beat(HT_NONSEQ, 32'h22, 1, SIZE_HALF, 32'h12340000, 0, 0, "wh22");
        beat(HT_NONSEQ, 32'h20, 0, SIZE_WORD, 0, 0, 32'h1234AA00, "r20");
        idle(2);

        beat(HT_NONSEQ, 32'h00, 1, SIZE_WORD, 32'h11223344, 0, 0, "w00");
        beat(HT_NONSEQ, 32'h100, 0, SIZE_WORD, 0, 1, 32'h0, "r100err");
        beat(HT_NONSEQ, 32'h03, 1, SIZE_HALF, 32'hFFFFFFFF, 1, 0, "wh03err");
        beat(HT_NONSEQ, 32'h100, 1, SIZE_WORD, 32'hFFFFFFFF, 1, 0, "w100err");
        beat(HT_NONSEQ, 32'h01, 0, 3'd3, 0, 1, 32'h0, "rsz3err");
        beat(HT_NONSEQ, 32'h00, 0, SIZE_WORD, 0, 0, 32'h11223344, "r00");
        idle(2);

        hburst = 3'b001;
        beat(HT_NONSEQ, 32'h30, 1, SIZE_WORD, 32'hA0A0A0A0, 0, 0, "bw30");
        beat(HT_SEQ, 32'h34, 1, SIZE_WORD, 32'hB1B1B1B1, 0, 0, "bw34");
        beat(HT_BUSY, 32'h38, 1, SIZE_WORD, 32'h0, 0, 0, "busy");
        beat(HT_SEQ, 32'h38, 1, SIZE_WORD, 32'hC2C2C2C2, 0, 0, "bw38");
        beat(HT_SEQ, 32'h3C, 1, SIZE_WORD, 32'hD3D3D3D3, 0, 0, "bw3c");
        beat(HT_NONSEQ, 32'h30, 0, SIZE_WORD, 0, 0, 32'hA0A0A0A0, "br30");
        beat(HT_SEQ, 32'h34, 0, SIZE_WORD, 0, 0, 32'hB1B1B1B1, "br34");
        beat(HT_SEQ, 32'h38, 0, SIZE_WORD, 0, 0, 32'hC2C2C2C2, "br38");
        beat(HT_SEQ, 32'h3C, 0, SIZE_WORD, 0, 0, 32'hD3D3D3D3, "br3c");
        beat(HT_NONSEQ, 32'hF8, 1, SIZE_WORD, 32'h0F0F0F0F, 0, 0, "bwf8");
        beat(HT_SEQ, 32'hFC, 1, SIZE_WORD, 32'h5A5A5A5A, 0, 0, "bwfc");
        beat(HT_SEQ, 32'h100, 1, SIZE_WORD, 32'h99999999, 1, 0, "bw100");
        beat(HT_NONSEQ, 32'hFC, 0, SIZE_WORD, 0, 0, 32'h5A5A5A5A, "brfc");
        hburst = 3'b000;
        idle(2);

        sel = 1'b1;
        beat(HT_NONSEQ, 32'h04, 1, SIZE_WORD, 32'h0BADF00D, 0, 0, "ws_w04");
        beat(HT_NONSEQ, 32'h04, 0, SIZE_WORD, 0, 0, 32'h0BADF00D, "ws_r04a");
        beat(HT_NONSEQ, 32'h04, 0, SIZE_WORD, 0, 0, 32'h0BADF00D, "ws_r04b");
        beat(HT_NONSEQ, 32'h08, 1, SIZE_WORD, 32'h77777777, 0, 0, "ws_w08");
        beat(HT_NONSEQ, 32'h08, 0, SIZE_WORD, 0, 0, 32'h77777777, "ws_r08");
        idle(2);

        hsel   = 1'b1;
        htrans = HT_NONSEQ;
        haddr  = 32'h08;
        hwrite = 1'b1;
        hsize  = SIZE_WORD;
        hwdata = 32'h0;
        @(posedge HCLK);
        #1;
        htrans = HT_IDLE;
        hwdata = 32'hCAFEF00D;
        @(posedge HCLK);
        #1;
        check("rstmid_in_wait", 32'(hreadyout), 32'd0);
        HRESETn = 1'b0;
        #1;
        check("rstmid_hreadyout", 32'(hreadyout), 32'd1);
        check("rstmid_hresp", 32'(hresp), 32'd0);
        check("rstmid_hrdata", hrdata, 32'h0);
        repeat (2) @(posedge HCLK);
        #2 HRESETn = 1'b1;
        pend = 32'h0;
        beat(HT_NONSEQ, 32'h08, 0, SIZE_WORD, 0, 0, 32'h0, "rst_r08");
        beat(HT_NONSEQ, 32'h04, 0, SIZE_WORD, 0, 0, 32'h0, "rst_r04");
        idle(3);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
